// File: rtl/scp_mem_pkg.sv
// Shared constants for the SCP data-memory stage: MMIO address map, STATUS bit layout,
// reset values and the MMIO address decoder used by scp_dmem_mmio.
// Pure declarations, so there is no latency and no backpressure.
package scp_mem_pkg;

   localparam logic [31:0] MMIO_BASE     = 32'h0000_1000;
   localparam logic [31:0] ADDR_TXDATA   = MMIO_BASE + 32'h0;
   localparam logic [31:0] ADDR_STATUS   = MMIO_BASE + 32'h4;
   localparam logic [31:0] ADDR_TIMER    = MMIO_BASE + 32'h8;
   localparam logic [31:0] ADDR_TIMERCMP = MMIO_BASE + 32'hC;

   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_OVF   = 2;
   localparam int ST_MATCH = 3;

   localparam logic [31:0] TIMERCMP_RST = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      TGT_NONE,
      TGT_RAM,
      TGT_TXDATA,
      TGT_STATUS,
      TGT_TIMER,
      TGT_TIMERCMP
   } tgt_e;

   // Decode a word address into an MMIO target; RAM hits are resolved by the caller
   // because the RAM size is a parameter of the top.
   function automatic tgt_e mmio_decode(input logic [29:0] waddr);
      tgt_e t;
      case ({waddr, 2'b00})
         ADDR_TXDATA:   t = TGT_TXDATA;
         ADDR_STATUS:   t = TGT_STATUS;
         ADDR_TIMER:    t = TGT_TIMER;
         ADDR_TIMERCMP: t = TGT_TIMERCMP;
         default:       t = TGT_NONE;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/scp_sync_fifo.sv
// Synchronous FIFO with registered storage; head_o shows the oldest entry (0 when empty).
// Latency: a pushed entry is visible at head_o one cycle after the push edge, no bypass.
// Backpressure: push while full is accepted only if a pop happens the same cycle, else ovf_o pulses.
// Ports: clk/reset (sync, active-high), push_i/data_i write side, pop_i read side,
//        head_o/full_o/empty_o status, ovf_o one-cycle pulse for a dropped push.
module scp_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             ovf_o
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == (PW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign pop_ok  = pop_i & ~empty_o;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push_ok = push_i & (~full_o | pop_ok);
   assign ovf_o   = push_i & full_o & ~pop_ok;
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers are PW bits wide, so increments wrap modulo DEPTH.
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; the emptied pointers make stale contents invisible.
   always_ff @(posedge clk) begin
      if (push_ok && !reset) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/scp_dmem_mmio.sv
// SCP data-memory stage: word RAM, TX byte FIFO, free-running timer with compare, STATUS register.
// Latency: ReadData is combinational in the access cycle; all writes take effect at the rising edge.
// Backpressure: the core is never stalled; tx_valid/tx_ready drains the FIFO, a push into a full FIFO sets OVF.
// Ports: clk/reset (sync, active-high); MemWrite/ALUResult/WriteData from core; ReadData to core;
//        tx_data/tx_valid/tx_ready byte stream; timer_irq mirrors STATUS.MATCH.
module scp_dmem_mmio
   import scp_mem_pkg::*;
#(
   parameter int RAM_WORDS  = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        timer_irq
);

   localparam int AW = $clog2(RAM_WORDS);

   logic [31:0]   ram_q [RAM_WORDS];
   logic [AW-1:0] ram_idx;
   logic          ram_hit;
   tgt_e          tgt;

   logic [31:0] timer_q, timer_d;
   logic [31:0] timercmp_q, timercmp_d;
   logic        match_q, match_d;
   logic        ovf_q, ovf_d;
   logic [31:0] status;

   logic wr_ram, wr_tx, wr_status, wr_timer, wr_timercmp;
   logic fifo_full, fifo_empty, fifo_ovf, fifo_pop;
   logic unused_addr_bits;

   // Word access only: the byte-offset bits do not take part in decode.
   assign unused_addr_bits = ^ALUResult[1:0];

   assign ram_idx = ALUResult[AW+1:2];
   assign ram_hit = (ALUResult[31:AW+2] == '0);

   always_comb begin
      tgt = TGT_NONE;
      if (ram_hit) tgt = TGT_RAM;
      else         tgt = mmio_decode(ALUResult[31:2]);
   end

   assign wr_ram      = MemWrite & (tgt == TGT_RAM);
   assign wr_tx       = MemWrite & (tgt == TGT_TXDATA);
   assign wr_status   = MemWrite & (tgt == TGT_STATUS);
   assign wr_timer    = MemWrite & (tgt == TGT_TIMER);
   assign wr_timercmp = MemWrite & (tgt == TGT_TIMERCMP);

   assign fifo_pop = tx_valid & tx_ready;

   scp_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (wr_tx),
      .pop_i   (fifo_pop),
      .data_i  (WriteData[7:0]),
      .head_o  (tx_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .ovf_o   (fifo_ovf)
   );

   assign tx_valid  = ~fifo_empty;
   assign timer_irq = match_q;

   always_comb begin
      status           = '0;
      status[ST_EMPTY] = fifo_empty;
      status[ST_FULL]  = fifo_full;
      status[ST_OVF]   = ovf_q;
      status[ST_MATCH] = match_q;
   end

   always_comb begin
      // Compare uses the pre-update counter; a set event outranks a W1C in the same cycle.
      match_d    = (timer_q == timercmp_q) | (match_q & ~(wr_status & WriteData[ST_MATCH]));
      ovf_d      = fifo_ovf | (ovf_q & ~(wr_status & WriteData[ST_OVF]));
      timer_d    = wr_timer ? WriteData : timer_q + 32'd1;
      timercmp_d = wr_timercmp ? WriteData : timercmp_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q    <= '0;
         timercmp_q <= TIMERCMP_RST;
         match_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         timer_q    <= timer_d;
         timercmp_q <= timercmp_d;
         match_q    <= match_d;
         ovf_q      <= ovf_d;
      end
   end

   // RAM contents survive reset; only the store issued during reset is dropped.
   always_ff @(posedge clk) begin
      if (wr_ram && !reset) ram_q[ram_idx] <= WriteData;
   end

   always_comb begin
      case (tgt)
         TGT_RAM:      ReadData = ram_q[ram_idx];
         TGT_STATUS:   ReadData = status;
         TGT_TIMER:    ReadData = timer_q;
         TGT_TIMERCMP: ReadData = timercmp_q;
         default:      ReadData = '0;
      endcase
   end

endmodule

// File: tb/tb_scp_dmem_mmio.sv
module tb_scp_dmem_mmio;

   localparam logic [31:0] A_TX  = 32'h1000;
   localparam logic [31:0] A_ST  = 32'h1004;
   localparam logic [31:0] A_TM  = 32'h1008;
   localparam logic [31:0] A_CMP = 32'h100C;
   localparam int          NW    = 64;
   localparam int          FD    = 4;

   logic        clk = 1'b0;
   logic        reset, MemWrite, tx_ready;
   logic [31:0] ALUResult, WriteData, ReadData;
   logic [7:0]  tx_data;
   logic        tx_valid, timer_irq;

   scp_dmem_mmio #(.RAM_WORDS(NW), .FIFO_DEPTH(FD)) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .ALUResult (ALUResult),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .timer_irq (timer_irq)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: memory as an array, FIFO as a queue, timer/flags as plain values.
   logic [31:0] m_ram [NW];
   bit          m_known [NW];
   logic [7:0]  m_q [$];
   bit          m_ovf, m_match;
   logic [31:0] m_timer, m_cmp;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wd;
      bit          rdy;
      bit          chk_rd;
      logic [31:0] rd;
      bit          vld;
      logic [7:0]  txd;
      bit          irq;
   } vec_t;

   vec_t tbl [29];

   function automatic vec_t mk(bit we, logic [31:0] a, logic [31:0] wd, bit rdy,
                               bit chk, logic [31:0] rd, bit vld, logic [7:0] txd, bit irq);
      vec_t v;
      v.we = we; v.addr = a; v.wd = wd; v.rdy = rdy;
      v.chk_rd = chk; v.rd = rd; v.vld = vld; v.txd = txd; v.irq = irq;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input bit rdy, input bit rst);
      @(negedge clk);
      MemWrite  = we;
      ALUResult = a;
      WriteData = wd;
      tx_ready  = rdy;
      reset     = rst;
      #1;
   endtask

   task automatic model_step;
      int  widx;
      bit  is_tx, is_st, is_tm, is_cmp, full, do_pop, oset, mset;
      if (reset) begin
         m_q.delete();
         m_ovf = 0; m_match = 0; m_timer = 0; m_cmp = 32'hFFFF_FFFF;
         return;
      end
      widx   = int'(ALUResult[31:2]);
      is_tx  = ({ALUResult[31:2], 2'b00} == A_TX);
      is_st  = ({ALUResult[31:2], 2'b00} == A_ST);
      is_tm  = ({ALUResult[31:2], 2'b00} == A_TM);
      is_cmp = ({ALUResult[31:2], 2'b00} == A_CMP);
      full   = (m_q.size() == FD);
      do_pop = (m_q.size() != 0) && tx_ready;
      mset   = (m_timer == m_cmp);
      oset   = 0;
      if (do_pop) void'(m_q.pop_front());
      if (MemWrite && is_tx) begin
         if (!full || do_pop) m_q.push_back(WriteData[7:0]);
         else oset = 1;
      end
      m_match = mset || (m_match && !(MemWrite && is_st && WriteData[3]));
      m_ovf   = oset || (m_ovf && !(MemWrite && is_st && WriteData[2]));
      m_timer = (MemWrite && is_tm) ? WriteData : m_timer + 32'd1;
      if (MemWrite && is_cmp) m_cmp = WriteData;
      if (MemWrite && widx < NW) begin
         m_ram[widx]   = WriteData;
         m_known[widx] = 1;
      end
   endtask

   task automatic tick;
      @(posedge clk);
      model_step();
   endtask

   task automatic check_model(input string tag);
      int          widx;
      bit          known;
      logic [31:0] exp;
      widx  = int'(ALUResult[31:2]);
      known = 1;
      if (widx < NW) begin
         known = m_known[widx];
         exp   = m_ram[widx];
      end else begin
         case ({ALUResult[31:2], 2'b00})
            A_ST:    exp = {28'b0, m_match, m_ovf, m_q.size() == FD, m_q.size() == 0};
            A_TM:    exp = m_timer;
            A_CMP:   exp = m_cmp;
            default: exp = 32'h0;
         endcase
      end
      if (known) check({tag, " rdata"}, ReadData, exp);
      check({tag, " tx_valid"}, {31'b0, tx_valid}, {31'b0, m_q.size() != 0});
      check({tag, " tx_data"}, {24'b0, tx_data}, {24'b0, (m_q.size() != 0) ? m_q[0] : 8'h00});
      check({tag, " irq"}, {31'b0, timer_irq}, {31'b0, m_match});
   endtask

   initial begin
      // Test-plan items 1-3 as cycle vectors: inputs this cycle, outputs seen before the edge.
      tbl[0]  = mk(0, A_ST,  0, 0, 1, 32'h1, 0, 8'h00, 0);
      tbl[1]  = mk(1, 32'h8, 32'hDEADBEEF, 0, 0, 0, 0, 8'h00, 0);
      tbl[2]  = mk(0, 32'h8, 0, 0, 1, 32'hDEADBEEF, 0, 8'h00, 0);
      tbl[3]  = mk(0, 32'h2000, 0, 0, 1, 32'h0, 0, 8'h00, 0);
      tbl[4]  = mk(1, A_TX, 32'h41, 0, 1, 32'h0, 0, 8'h00, 0);
      tbl[5]  = mk(1, A_TX, 32'h42, 0, 1, 32'h0, 1, 8'h41, 0);
      tbl[6]  = mk(1, A_TX, 32'h43, 0, 1, 32'h0, 1, 8'h41, 0);
      tbl[7]  = mk(1, A_TX, 32'h44, 0, 1, 32'h0, 1, 8'h41, 0);
      tbl[8]  = mk(0, A_ST, 0, 0, 1, 32'h2, 1, 8'h41, 0);
      tbl[9]  = mk(1, A_TX, 32'h45, 0, 1, 32'h0, 1, 8'h41, 0);
      tbl[10] = mk(0, A_ST, 0, 0, 1, 32'h6, 1, 8'h41, 0);
      tbl[11] = mk(0, A_ST, 0, 1, 1, 32'h6, 1, 8'h41, 0);
      tbl[12] = mk(0, A_ST, 0, 1, 1, 32'h4, 1, 8'h42, 0);
      tbl[13] = mk(0, A_ST, 0, 1, 1, 32'h4, 1, 8'h43, 0);
      tbl[14] = mk(0, A_ST, 0, 1, 1, 32'h4, 1, 8'h44, 0);
      tbl[15] = mk(0, A_ST, 0, 1, 1, 32'h5, 0, 8'h00, 0);
      tbl[16] = mk(1, A_ST, 32'h4, 0, 1, 32'h5, 0, 8'h00, 0);
      tbl[17] = mk(0, A_ST, 0, 0, 1, 32'h1, 0, 8'h00, 0);
      tbl[18] = mk(1, A_TX, 32'h61, 0, 1, 32'h0, 0, 8'h00, 0);
      tbl[19] = mk(1, A_TX, 32'h62, 0, 1, 32'h0, 1, 8'h61, 0);
      tbl[20] = mk(1, A_TX, 32'h63, 0, 1, 32'h0, 1, 8'h61, 0);
      tbl[21] = mk(1, A_TX, 32'h64, 0, 1, 32'h0, 1, 8'h61, 0);
      tbl[22] = mk(1, A_TX, 32'h55, 1, 1, 32'h0, 1, 8'h61, 0);
      tbl[23] = mk(0, A_ST, 0, 0, 1, 32'h2, 1, 8'h62, 0);
      tbl[24] = mk(0, A_ST, 0, 1, 1, 32'h2, 1, 8'h62, 0);
      tbl[25] = mk(0, A_ST, 0, 1, 1, 32'h0, 1, 8'h63, 0);
      tbl[26] = mk(0, A_ST, 0, 1, 1, 32'h0, 1, 8'h64, 0);
      tbl[27] = mk(0, A_ST, 0, 1, 1, 32'h0, 1, 8'h55, 0);
      tbl[28] = mk(0, A_ST, 0, 0, 1, 32'h1, 0, 8'h00, 0);

      MemWrite = 0; ALUResult = 0; WriteData = 0; tx_ready = 0; reset = 1;
      drive(0, 0, 0, 0, 1); tick();
      drive(0, 0, 0, 0, 1); tick();

      for (int i = 0; i < 29; i++) begin
         drive(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].rdy, 0);
         if (tbl[i].chk_rd) check($sformatf("vec%0d rdata", i), ReadData, tbl[i].rd);
         check($sformatf("vec%0d tx_valid", i), {31'b0, tx_valid}, {31'b0, tbl[i].vld});
         check($sformatf("vec%0d tx_data", i), {24'b0, tx_data}, {24'b0, tbl[i].txd});
         check($sformatf("vec%0d irq", i), {31'b0, timer_irq}, {31'b0, tbl[i].irq});
         tick();
      end

      // Timer compare: counter loaded with 10 reaches 20 as its pre-edge value on the 11th edge.
      drive(1, A_CMP, 32'd20, 0, 0); tick();
      drive(1, A_TM, 32'd10, 0, 0); tick();
      for (int j = 0; j < 14; j++) begin
         drive(0, A_TM, 0, 0, 0);
         check($sformatf("match timer j%0d", j), ReadData, 32'd10 + 32'(j));
         check($sformatf("match irq j%0d", j), {31'b0, timer_irq}, {31'b0, j >= 11});
         tick();
      end
      drive(1, A_ST, 32'h8, 0, 0);
      check("irq before w1c", {31'b0, timer_irq}, 32'h1);
      tick();
      drive(0, A_ST, 0, 0, 0);
      check("status after w1c", ReadData, 32'h1);
      check("irq after w1c", {31'b0, timer_irq}, 32'h0);
      tick();

      // Timer wrap and load-over-increment.
      drive(1, A_TM, 32'hFFFF_FFFE, 0, 0); tick();
      drive(0, A_TM, 0, 0, 0);
      check("wrap t0", ReadData, 32'hFFFF_FFFE); tick();
      drive(0, A_TM, 0, 0, 0);
      check("wrap t1", ReadData, 32'hFFFF_FFFF); tick();
      drive(0, A_TM, 0, 0, 0);
      check("wrap t2", ReadData, 32'h0); tick();
      drive(1, A_TM, 32'h100, 0, 0); tick();
      drive(0, A_TM, 0, 0, 0);
      check("load beats inc", ReadData, 32'h100); tick();

      // Reset with queued bytes, MATCH set and a store in flight.
      drive(1, 32'h10, 32'hCAFEF00D, 0, 0); tick();
      drive(1, A_CMP, 32'h0, 0, 0); tick();
      drive(1, A_TM, 32'h0, 0, 0); tick();
      drive(0, A_ST, 0, 0, 0); tick();
      drive(1, A_TX, 32'hA1, 0, 0); tick();
      drive(1, A_TX, 32'hA2, 0, 0); tick();
      drive(1, A_TX, 32'hA3, 0, 0); tick();
      drive(0, A_ST, 0, 0, 0);
      check("pre-reset status", ReadData, 32'h8);
      check("pre-reset irq", {31'b0, timer_irq}, 32'h1);
      check("pre-reset head", {24'b0, tx_data}, 32'hA1);
      drive(1, A_TX, 32'h77, 0, 1); tick();
      drive(0, A_TM, 0, 0, 0);
      check("post-reset timer", ReadData, 32'h0);
      check("post-reset tx_valid", {31'b0, tx_valid}, 32'h0);
      check("post-reset tx_data", {24'b0, tx_data}, 32'h0);
      check("post-reset irq", {31'b0, timer_irq}, 32'h0);
      tick();
      drive(0, A_ST, 0, 0, 0);
      check("post-reset status", ReadData, 32'h1);
      tick();
      drive(0, 32'h10, 0, 0, 0);
      check("ram kept over reset", ReadData, 32'hCAFEF00D);
      tick();

      // Randomised traffic against the reference model.
      for (int k = 0; k < 600; k++) begin
         int          sel;
         bit          we, rdy, rst;
         logic [31:0] a, wd;
         sel = $urandom_range(0, 9);
         we  = $urandom_range(0, 1) == 1;
         rdy = $urandom_range(0, 2) != 0;
         rst = $urandom_range(0, 99) == 0;
         wd  = $urandom;
         case (sel)
            0, 1:    a = {24'b0, 6'($urandom_range(0, NW - 1)), 2'($urandom_range(0, 3))};
            2, 3, 4: a = A_TX;
            5:       begin a = A_ST; wd = {28'b0, 4'($urandom_range(0, 15))}; end
            6:       begin a = A_TM; if ($urandom_range(0, 3) != 0) we = 0; end
            7:       begin a = A_CMP; wd = m_timer + 32'($urandom_range(0, 6)); end
            8:       a = 32'h1010 + 32'($urandom_range(0, 15) * 4);
            default: a = 32'h0008_0000 + 32'($urandom);
         endcase
         drive(we, a, wd, rdy, rst);
         check_model($sformatf("rnd%0d", k));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
